fir_xifu_regfile_sb: RTL and testbench

Parametrised XIFU register file for the FIR coprocessor. Supports NB_RD read ports and NB_WR write ports, with write-back bypass on every read port. A per-register scoreboard counts outstanding writes, so the EX stage sees RAW hazards and issue back-pressure without a separate hazard unit. It sits between the XIFU EX stage (reads, issue) and the WB stage (writes, retire).

---
 rtl/fir_xifu_regfile_sb.sv | 120 ++++++++++++
 tb/tb_fir_xifu_regfile_sb.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_xifu_regfile_sb.sv
// fir_xifu_regfile_sb: FIR XIFU register file with write-back bypass and a
// per-register write scoreboard that flags RAW hazards and throttles issue.
// Ports: clk_i, rst_ni (sync, active-low)
//   rd_addr_i -> rd_data_o, hazard_o   : NB_RD bypassed read ports
//   issue_valid_i, issue_rd_i          : EX issue of a register writer
//   issue_ready_o                      : issue accepted (dest not full)
//   wb_write_i, wb_rd_i, wb_data_i     : NB_WR write-back/retire ports
//   flush_i                            : drop all outstanding writes
//   underflow_o                        : sticky, retire with no pending write
module fir_xifu_regfile_sb #(
  parameter int NB_REGS  = 8,
  parameter int DATA_W   = 32,
  parameter int NB_RD    = 3,
  parameter int NB_WR    = 2,
  parameter int MAX_PEND = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NB_RD*5-1:0]      rd_addr_i,
  output logic [NB_RD*DATA_W-1:0] rd_data_o,
  output logic [NB_RD-1:0]        hazard_o,
  input  logic                    issue_valid_i,
  input  logic [4:0]              issue_rd_i,
  output logic                    issue_ready_o,
  input  logic [NB_WR-1:0]        wb_write_i,
  input  logic [NB_WR*5-1:0]      wb_rd_i,
  input  logic [NB_WR*DATA_W-1:0] wb_data_i,
  input  logic                    flush_i,
  output logic                    underflow_o
);

  localparam int CW = $clog2(MAX_PEND + 1);
  localparam int AW = $clog2(NB_REGS);
  localparam int HW = $clog2(NB_WR + 1);
  localparam int SW = ((CW > HW) ? CW : HW) + 1;

  logic [DATA_W-1:0] regs   [NB_REGS];
  logic [CW-1:0]     cnt    [NB_REGS];
  logic              uf_q;

  logic              wr_hit [NB_REGS];
  logic [DATA_W-1:0] wr_val [NB_REGS];
  logic [HW-1:0]     hits   [NB_REGS];
  logic [SW-1:0]     sum    [NB_REGS];
  logic [CW-1:0]     cnt_d  [NB_REGS];
  logic              uf_d;
  logic              iss_ok;
  logic              fire;

  function automatic logic in_rng(input logic [4:0] a);
    return {27'd0, a} < NB_REGS;
  endfunction

  // Highest-index WB port wins; hits counts retires per register.
  always_comb begin
    for (int r = 0; r < NB_REGS; r++) begin
      wr_hit[r] = 1'b0;
      wr_val[r] = '0;
      hits[r]   = '0;
      for (int w = 0; w < NB_WR; w++) begin
        if (wb_write_i[w] && wb_rd_i[w*5 +: 5] == 5'(r)) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wb_data_i[w*DATA_W +: DATA_W];
          hits[r]   = hits[r] + HW'(1);
        end
      end
    end
  end

  // Out-of-range destinations are accepted but never tracked.
  assign iss_ok = in_rng(issue_rd_i);
  assign issue_ready_o = !iss_ok ||
    (cnt[issue_rd_i[AW-1:0]] != CW'(MAX_PEND));
  assign fire = issue_valid_i && issue_ready_o && iss_ok && !flush_i;

  always_comb begin
    uf_d = uf_q;
    for (int r = 0; r < NB_REGS; r++) begin
      sum[r] = SW'(cnt[r]) + SW'(fire && issue_rd_i == 5'(r));
      if (flush_i) begin
        cnt_d[r] = '0;
      end else if (sum[r] < SW'(hits[r])) begin
        cnt_d[r] = '0;
        uf_d     = 1'b1;
      end else begin
        cnt_d[r] = CW'(sum[r] - SW'(hits[r]));
      end
    end
  end

  for (genvar p = 0; p < NB_RD; p++) begin : g_rd
    logic [4:0]    a;
    logic [AW-1:0] i;
    assign a = rd_addr_i[p*5 +: 5];
    assign i = a[AW-1:0];
    assign rd_data_o[p*DATA_W +: DATA_W] =
      !in_rng(a) ? '0 : (wr_hit[i] ? wr_val[i] : regs[i]);
    // A pending write retiring this cycle is covered by the bypass.
    assign hazard_o[p] = in_rng(a) && (SW'(cnt[i]) > SW'(hits[i]));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int r = 0; r < NB_REGS; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      uf_q <= 1'b0;
    end else begin
      for (int r = 0; r < NB_REGS; r++) begin
        if (wr_hit[r]) regs[r] <= wr_val[r];
        cnt[r] <= cnt_d[r];
      end
      uf_q <= uf_d;
    end
  end

  assign underflow_o = uf_q;

endmodule

// File: tb/tb_fir_xifu_regfile_sb.sv
// tb_fir_xifu_regfile_sb: directed bench for fir_xifu_regfile_sb with a
// behavioural register/scoreboard model and literal expectations.
module tb_fir_xifu_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] rd_addr;
  logic [95:0] rd_data;
  logic [2:0]  hazard;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [1:0]  wb_write;
  logic [9:0]  wb_rd;
  logic [63:0] wb_data;
  logic        flush;
  logic        uf;

  fir_xifu_regfile_sb dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .hazard_o(hazard),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
    .issue_ready_o(issue_ready),
    .wb_write_i(wb_write), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .flush_i(flush), .underflow_o(uf)
  );

  always #5 clk = ~clk;

  // Model: architectural values, outstanding-write counts, sticky flag.
  logic [31:0] m_reg [8];
  int          m_cnt [8];
  bit          m_uf;

  typedef struct {
    int          kind;
    int          port;
    logic [31:0] val;
  } lit_t;
  lit_t lit_q[$];

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  function automatic bit m_ready(logic [4:0] a);
    return (a >= 5'd8) || (m_cnt[a[2:0]] != 3);
  endfunction

  always @(posedge clk) begin
    int inc_a;
    int h;
    int t;
    if (!rst_n) begin
      for (int r = 0; r < 8; r++) begin
        m_reg[r] = '0;
        m_cnt[r] = 0;
      end
      m_uf = 0;
    end else begin
      inc_a = -1;
      if (issue_valid && !flush && issue_rd < 5'd8 && m_ready(issue_rd))
        inc_a = int'(issue_rd);
      for (int r = 0; r < 8; r++) begin
        h = 0;
        for (int w = 0; w < 2; w++)
          if (wb_write[w] && int'(wb_rd[w*5 +: 5]) == r) h++;
        if (flush) begin
          m_cnt[r] = 0;
        end else begin
          t = m_cnt[r] + ((inc_a == r) ? 1 : 0);
          if (t < h) begin
            m_uf = 1;
            t = 0;
          end else begin
            t = t - h;
          end
          m_cnt[r] = t;
        end
      end
      for (int w = 0; w < 2; w++)
        if (wb_write[w] && wb_rd[w*5 +: 5] < 5'd8)
          m_reg[wb_rd[w*5 +: 3]] = wb_data[w*32 +: 32];
    end
  end

  task automatic cmp(string nm, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic string kname(int k);
    case (k)
      0: return "lit_rd_data";
      1: return "lit_hazard";
      2: return "lit_issue_ready";
      default: return "lit_underflow";
    endcase
  endfunction

  always @(negedge clk) begin
    logic [4:0]  a;
    logic [31:0] ed;
    logic [31:0] got;
    bit          eh;
    int          h;
    lit_t        l;
    if (chk_en) begin
      for (int p = 0; p < 3; p++) begin
        a  = rd_addr[p*5 +: 5];
        ed = '0;
        eh = 0;
        h  = 0;
        if (a < 5'd8) begin
          ed = m_reg[a[2:0]];
          for (int w = 0; w < 2; w++)
            if (wb_write[w] && wb_rd[w*5 +: 5] == a) begin
              ed = wb_data[w*32 +: 32];
              h++;
            end
          eh = (m_cnt[a[2:0]] - h) > 0;
        end
        cmp($sformatf("rd_data[%0d]", p), rd_data[p*32 +: 32], ed);
        cmp($sformatf("hazard[%0d]", p), {31'd0, hazard[p]}, {31'd0, eh});
      end
      cmp("issue_ready", {31'd0, issue_ready}, {31'd0, m_ready(issue_rd)});
      cmp("underflow", {31'd0, uf}, {31'd0, m_uf});
    end
    while (lit_q.size() > 0) begin
      l = lit_q.pop_front();
      case (l.kind)
        0: got = rd_data[l.port*32 +: 32];
        1: got = {31'd0, hazard[l.port]};
        2: got = {31'd0, issue_ready};
        default: got = {31'd0, uf};
      endcase
      cmp(kname(l.kind), got, l.val);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1;
    issue_valid = 1'b0;
    wb_write = '0;
    flush = 1'b0;
  endtask

  task automatic set_rd(int p, logic [4:0] a);
    rd_addr[p*5 +: 5] = a;
  endtask

  task automatic set_wb(int w, logic [4:0] a, logic [31:0] d);
    wb_write[w] = 1'b1;
    wb_rd[w*5 +: 5] = a;
    wb_data[w*32 +: 32] = d;
  endtask

  task automatic set_iss(logic [4:0] a);
    issue_valid = 1'b1;
    issue_rd = a;
  endtask

  task automatic lit(int k, int p, logic [31:0] v);
    lit_q.push_back('{k, p, v});
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr = '0;
    issue_valid = 1'b0;
    issue_rd = '0;
    wb_write = '0;
    wb_rd = '0;
    wb_data = '0;
    flush = 1'b0;
    step();
    step();
    chk_en = 1;
    idle();
    for (int p = 0; p < 3; p++) begin
      lit(0, p, 32'h0);
      lit(1, p, 32'h0);
    end
    lit(2, 0, 32'h1);
    lit(3, 0, 32'h0);
    step();

    // Reset mid-operation: cnt[2]=2, reg[2]=CAFE.
    set_iss(5'd2);
    step(); step(); step();
    idle();
    set_wb(0, 5'd2, 32'hCAFE);
    issue_rd = 5'd2;
    lit(2, 0, 32'h0);
    step();
    idle();
    set_rd(0, 5'd2);
    lit(0, 0, 32'hCAFE);
    lit(1, 0, 32'h1);
    lit(2, 0, 32'h1);
    step();
    rst_n = 1'b0;
    set_iss(5'd2);
    set_wb(1, 5'd2, 32'h5555);
    flush = 1'b1;
    step();
    idle();
    set_rd(0, 5'd2);
    issue_rd = 5'd2;
    lit(0, 0, 32'h0);
    lit(1, 0, 32'h0);
    lit(2, 0, 32'h1);
    lit(3, 0, 32'h0);
    step();

    // Single pending write, bypassed on retire.
    set_iss(5'd3);
    step();
    idle();
    set_rd(0, 5'd3);
    lit(1, 0, 32'h1);
    step();
    set_wb(0, 5'd3, 32'h1234);
    lit(0, 0, 32'h1234);
    lit(1, 0, 32'h0);
    step();
    idle();
    issue_rd = 5'd3;
    lit(0, 0, 32'h1234);
    lit(1, 0, 32'h0);
    lit(2, 0, 32'h1);
    step();

    // Two WB ports to one register: port1 wins, both retire.
    set_iss(5'd5);
    step(); step();
    idle();
    set_wb(0, 5'd5, 32'hAAAA);
    set_wb(1, 5'd5, 32'hBBBB);
    set_rd(1, 5'd5);
    lit(0, 1, 32'hBBBB);
    lit(1, 1, 32'h0);
    step();
    idle();
    lit(0, 1, 32'hBBBB);
    lit(1, 1, 32'h0);
    lit(3, 0, 32'h0);
    step();

    // Saturation at MAX_PEND with a held issue.
    set_iss(5'd1);
    step(); step(); step();
    lit(2, 0, 32'h0);
    step();
    lit(2, 0, 32'h0);
    issue_valid = 1'b0;
    set_wb(0, 5'd1, 32'h11);
    set_rd(2, 5'd1);
    lit(1, 2, 32'h1);
    step();
    idle();
    lit(2, 0, 32'h1);
    lit(0, 2, 32'h11);
    lit(1, 2, 32'h1);
    step();
    set_wb(0, 5'd1, 32'h21);
    set_wb(1, 5'd1, 32'h22);
    lit(0, 2, 32'h22);
    lit(1, 2, 32'h0);
    step();
    idle();
    lit(1, 2, 32'h0);
    lit(3, 0, 32'h0);
    step();

    // Retire with no pending write: sticky underflow.
    set_wb(0, 5'd4, 32'h44);
    lit(3, 0, 32'h0);
    step();
    idle();
    set_rd(0, 5'd4);
    lit(3, 0, 32'h1);
    lit(0, 0, 32'h44);
    lit(1, 0, 32'h0);
    step();
    lit(3, 0, 32'h1);
    step();

    // Flush with a same-cycle issue.
    set_iss(5'd6);
    step();
    set_iss(5'd6);
    flush = 1'b1;
    set_rd(0, 5'd6);
    lit(1, 0, 32'h1);
    step();
    idle();
    lit(1, 0, 32'h0);
    lit(2, 0, 32'h1);
    step();

    // Out-of-range address 9 (aliases reg 1 in the low bits).
    set_rd(0, 5'd9);
    set_rd(1, 5'd1);
    set_wb(0, 5'd9, 32'hDEAD);
    set_iss(5'd9);
    lit(0, 0, 32'h0);
    lit(1, 0, 32'h0);
    lit(2, 0, 32'h1);
    step();
    idle();
    lit(0, 1, 32'h22);
    lit(1, 1, 32'h0);
    step();

    // Mixed traffic checked by the model alone.
    for (int i = 0; i < 60; i++) begin
      idle();
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd = 5'($urandom_range(0, 9));
      wb_write = 2'($urandom_range(0, 3));
      wb_rd = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
      wb_data = {$urandom, $urandom};
      flush = ($urandom_range(0, 9) == 0);
      for (int p = 0; p < 3; p++) set_rd(p, 5'($urandom_range(0, 9)));
      step();
    end

    idle();
    step();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
